// File: rtl/wt_dcache_ctrl_mp.sv
// Multi-port write-through dcache read controller: round-robin arbitration of core read ports onto one
// cache read port and one miss-unit port. Optional perf counters when WT_DCACHE_CTRL_PERF_EN is defined.
package wt_dcache_ctrl_mp_pkg;
  localparam int unsigned PLEN                = 32;
  localparam int unsigned DCACHE_SET_ASSOC    = 4;
  localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
  localparam int unsigned DCACHE_INDEX_WIDTH  = 12;
  localparam int unsigned DCACHE_TAG_WIDTH    = PLEN - DCACHE_INDEX_WIDTH;
  localparam int unsigned DCACHE_CL_IDX_WIDTH = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;
  localparam int unsigned CACHE_ID_WIDTH      = 2;

  typedef logic [3:0] dcs_data_t;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [1:0]                    data_size;
    logic                          data_req;
    logic                          kill_req;
    logic                          tag_valid;
    dcs_data_t                     dcs_data;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;
endpackage

module wt_dcache_ctrl_mp
  import wt_dcache_ctrl_mp_pkg::*;
#(
  parameter int unsigned               NumPorts   = 3,
  parameter logic [CACHE_ID_WIDTH-1:0] RdTxId     = CACHE_ID_WIDTH'(1),
  parameter logic [PLEN-1:0]           CachedBase = 32'h8000_0000,
  parameter logic [PLEN-1:0]           CachedSize = 32'h4000_0000
`ifdef WT_DCACHE_CTRL_PERF_EN
  , parameter int unsigned             CntWidth   = 32
`endif
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cache_en_i,
  input  dcache_req_i_t                  req_ports_i [NumPorts],
  output dcache_req_o_t                  req_ports_o [NumPorts],
  output logic                           miss_req_o,
  input  logic                           miss_ack_i,
  input  logic                           miss_replay_i,
  input  logic                           miss_rtrn_vld_i,
  output logic                           miss_we_o,
  output logic [63:0]                    miss_wdata_o,
  output logic [DCACHE_SET_ASSOC-1:0]    miss_vld_bits_o,
  output logic [PLEN-1:0]                miss_paddr_o,
  output logic                           miss_nc_o,
  output logic [2:0]                     miss_size_o,
  output logic [CACHE_ID_WIDTH-1:0]      miss_id_o,
  output dcs_data_t                      miss_dcs_data_o,
  input  logic                           wr_cl_vld_i,
  output logic [DCACHE_TAG_WIDTH-1:0]    rd_tag_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx_o,
  output logic [DCACHE_OFFSET_WIDTH-1:0] rd_off_o,
  output logic                           rd_req_o,
  output logic                           rd_tag_only_o,
  input  logic                           rd_ack_i,
  input  logic [63:0]                    rd_data_i,
  input  logic [DCACHE_SET_ASSOC-1:0]    rd_vld_bits_i,
  input  logic [DCACHE_SET_ASSOC-1:0]    rd_hit_oh_i
`ifdef WT_DCACHE_CTRL_PERF_EN
  , output logic [CntWidth-1:0]          hit_cnt_o,
  output logic [CntWidth-1:0]            miss_cnt_o
`endif
);
  localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam logic [PortW-1:0] LastPort = PortW'(NumPorts - 1);

  typedef enum logic [2:0] {
    IDLE, READ, MISS_REQ, MISS_WAIT, REPLAY_REQ, REPLAY_READ, KILL_MISS_ACK, KILL_MISS
  } state_e;

  state_e                         state_q, state_d;
  logic [PortW-1:0]               owner_q, rr_q, winner;
  logic [DCACHE_TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [DCACHE_CL_IDX_WIDTH-1:0] idx_q;
  logic [DCACHE_OFFSET_WIDTH-1:0] off_q;
  logic [1:0]                     size_q;
  dcs_data_t                      dcs_q;
  logic [DCACHE_SET_ASSOC-1:0]    vld_q;
  logic                           rd_req_q, rd_ack_q;
  logic                           any_req, arb_en, gnt, rvalid, hit, rd_req, miss_req, miss_issue;
  logic [PLEN-1:0]                paddr;
  dcache_req_i_t                  owner_req, winner_req;

  assign owner_req  = req_ports_i[owner_q];
  assign winner_req = req_ports_i[winner];

  // Rotating priority: scan from rr_q upward with wrap-around.
  always_comb begin
    int unsigned p;
    any_req = 1'b0;
    winner  = '0;
    p       = 0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      p = 32'(rr_q) + k;
      if (p >= NumPorts) p = p - NumPorts;
      if (!any_req && req_ports_i[p].data_req) begin
        any_req = 1'b1;
        winner  = PortW'(p);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    arb_en     = 1'b0;
    gnt        = 1'b0;
    rvalid     = 1'b0;
    hit        = 1'b0;
    rd_req     = 1'b0;
    miss_req   = 1'b0;
    miss_issue = 1'b0;
    case (state_q)
      IDLE: arb_en = 1'b1;
      READ, REPLAY_READ: begin
        rd_req = 1'b1;
        if (owner_req.kill_req) begin
          rvalid  = 1'b1;
          state_d = IDLE;
        end else if (owner_req.tag_valid || state_q == REPLAY_READ) begin
          if (wr_cl_vld_i || !rd_ack_q) begin
            state_d = REPLAY_REQ;
          end else if ((|rd_hit_oh_i) && cache_en_i) begin
            rvalid  = 1'b1;
            hit     = 1'b1;
            arb_en  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        miss_req = 1'b1;
        if (owner_req.kill_req) begin
          rvalid  = 1'b1;
          state_d = miss_ack_i ? KILL_MISS : KILL_MISS_ACK;
        end else if (miss_replay_i) begin
          state_d = REPLAY_REQ;
        end else if (miss_ack_i) begin
          state_d    = MISS_WAIT;
          miss_issue = 1'b1;
        end
      end
      MISS_WAIT: begin
        if (owner_req.kill_req) begin
          rvalid  = 1'b1;
          state_d = miss_rtrn_vld_i ? IDLE : KILL_MISS;
        end else if (miss_rtrn_vld_i) begin
          rvalid  = 1'b1;
          state_d = IDLE;
        end
      end
      REPLAY_REQ: begin
        rd_req = 1'b1;
        if (owner_req.kill_req) begin
          rvalid  = 1'b1;
          state_d = IDLE;
        end else if (rd_ack_i) begin
          state_d = REPLAY_READ;
        end
      end
      KILL_MISS_ACK: begin
        miss_req = 1'b1;
        if (miss_replay_i)   state_d = IDLE;
        else if (miss_ack_i) state_d = KILL_MISS;
      end
      KILL_MISS: if (miss_rtrn_vld_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A hit completion frees the read port in the same cycle for the next grant.
    if (arb_en && any_req) begin
      rd_req = 1'b1;
      if (rd_ack_i) begin
        gnt     = 1'b1;
        state_d = READ;
      end
    end
  end

  assign tag_d = (state_q == READ && owner_req.tag_valid) ? owner_req.address_tag : tag_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      tag_q    <= '0;
      idx_q    <= '0;
      off_q    <= '0;
      size_q   <= '0;
      dcs_q    <= '0;
      vld_q    <= '0;
      rd_req_q <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      rd_req_q <= rd_req;
      rd_ack_q <= rd_ack_i;
      if (rd_req_q) vld_q <= rd_vld_bits_i;
      if (gnt) begin
        owner_q <= winner;
        rr_q    <= (winner == LastPort) ? '0 : winner + PortW'(1);
        idx_q   <= winner_req.address_index[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH];
        off_q   <= winner_req.address_index[DCACHE_OFFSET_WIDTH-1:0];
        size_q  <= winner_req.data_size;
        dcs_q   <= winner_req.dcs_data;
      end
    end
  end

  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
    assign req_ports_o[gi] = '{
      data_gnt:    rst_ni && gnt && (winner == PortW'(gi)),
      data_rvalid: rst_ni && rvalid && (owner_q == PortW'(gi)),
      data_rdata:  rd_data_i
    };
  end

  assign rd_req_o        = rst_ni && rd_req;
  assign rd_tag_only_o   = 1'b0;
  assign rd_tag_o        = tag_d;
  assign rd_idx_o        = (arb_en && any_req) ?
                           winner_req.address_index[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH] : idx_q;
  assign rd_off_o        = (arb_en && any_req) ?
                           winner_req.address_index[DCACHE_OFFSET_WIDTH-1:0] : off_q;

  assign paddr           = {tag_q, idx_q, off_q};
  assign miss_req_o      = rst_ni && miss_req;
  assign miss_we_o       = 1'b0;
  assign miss_wdata_o    = '0;
  assign miss_vld_bits_o = vld_q;
  assign miss_paddr_o    = paddr;
  assign miss_nc_o       = !cache_en_i || !((paddr >= CachedBase) && ((paddr - CachedBase) < CachedSize));
  assign miss_size_o     = miss_nc_o ? {1'b0, size_q} : 3'b111;
  assign miss_id_o       = RdTxId;
  assign miss_dcs_data_o = dcs_q;

`ifdef WT_DCACHE_CTRL_PERF_EN
  logic [CntWidth-1:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && !(&hit_cnt_q))         hit_cnt_q  <= hit_cnt_q + CntWidth'(1);
      if (miss_issue && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + CntWidth'(1);
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = hit ^ miss_issue;
`endif
endmodule

// File: tb/tb_wt_dcache_ctrl_mp.sv
// Directed bench for wt_dcache_ctrl_mp: arbitration, hits, NC miss, kill, replay and reset mid-miss.
module tb_wt_dcache_ctrl_mp;
  import wt_dcache_ctrl_mp_pkg::*;

  logic          clk = 1'b0;
  logic          rst_ni, cache_en;
  dcache_req_i_t req_i [3];
  dcache_req_o_t req_o [3];
  logic          miss_req, miss_ack, miss_replay, rtrn, miss_we, miss_nc, wr_cl;
  logic [63:0]   miss_wdata, rd_data;
  logic [3:0]    miss_vld, rd_vld, hit_oh;
  logic [31:0]   miss_paddr;
  logic [2:0]    miss_size;
  logic [1:0]    miss_id;
  dcs_data_t     miss_dcs;
  logic [19:0]   rd_tag;
  logic [7:0]    rd_idx;
  logic [3:0]    rd_off;
  logic          rd_req, rd_tag_only, rd_ack;
`ifdef WT_DCACHE_CTRL_PERF_EN
  logic [31:0]   hit_cnt, miss_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [2:0] gnt_v, rv_v;

  always #5 clk = ~clk;

  wt_dcache_ctrl_mp dut (
    .clk_i(clk), .rst_ni(rst_ni), .cache_en_i(cache_en),
    .req_ports_i(req_i), .req_ports_o(req_o),
    .miss_req_o(miss_req), .miss_ack_i(miss_ack), .miss_replay_i(miss_replay),
    .miss_rtrn_vld_i(rtrn), .miss_we_o(miss_we), .miss_wdata_o(miss_wdata),
    .miss_vld_bits_o(miss_vld), .miss_paddr_o(miss_paddr), .miss_nc_o(miss_nc),
    .miss_size_o(miss_size), .miss_id_o(miss_id), .miss_dcs_data_o(miss_dcs),
    .wr_cl_vld_i(wr_cl), .rd_tag_o(rd_tag), .rd_idx_o(rd_idx), .rd_off_o(rd_off),
    .rd_req_o(rd_req), .rd_tag_only_o(rd_tag_only), .rd_ack_i(rd_ack),
    .rd_data_i(rd_data), .rd_vld_bits_i(rd_vld), .rd_hit_oh_i(hit_oh)
`ifdef WT_DCACHE_CTRL_PERF_EN
    , .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
`endif
  );

  always_comb begin
    gnt_v = '0;
    rv_v  = '0;
    for (int i = 0; i < 3; i++) begin
      gnt_v[i] = req_o[i].data_gnt;
      rv_v[i]  = req_o[i].data_rvalid;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    rd_ack = 0; miss_ack = 0; miss_replay = 0; rtrn = 0; wr_cl = 0; hit_oh = '0;
    for (int i = 0; i < 3; i++) begin
      req_i[i].data_req = 0; req_i[i].tag_valid = 0; req_i[i].kill_req = 0;
    end
  endtask

  // Advance to the next negedge (one posedge passes) and clear per-cycle pulses.
  task automatic nxt();
    @(negedge clk);
    idle_in();
  endtask

  task automatic txn(input string what);
    $display("txn t=%0t %s", $time, what);
  endtask

  initial begin
    rst_ni = 0; cache_en = 1; rd_vld = 4'b1011; rd_data = 64'hdead_beef_0123_4567;
    for (int i = 0; i < 3; i++) req_i[i] = '0;
    idle_in();

    // Reset: outputs forced low even with a live request and ack.
    @(negedge clk);
    req_i[0].data_req = 1; rd_ack = 1; #1;
    txn("reset");
    check_eq("rst_gnt", gnt_v, 3'b000);
    check_eq("rst_rd_req", rd_req, 0);
    check_eq("rst_miss_req", miss_req, 0);
    check_eq("rst_paddr", miss_paddr, 0);
    check_eq("rst_nc", miss_nc, 1);
    check_eq("rst_size", miss_size, 0);
    check_eq("miss_id", miss_id, 1);
    check_eq("ties", {miss_we, rd_tag_only, |miss_wdata}, 3'b000);
    nxt();
    rst_ni = 1;

    // A: port0 granted (rr=0)
    req_i[0].data_req = 1; req_i[0].address_index = 12'h010; req_i[0].dcs_data = 4'h5; rd_ack = 1; #1;
    txn("grant port0");
    check_eq("A_gnt", gnt_v, 3'b001);
    check_eq("A_rd_req", rd_req, 1);
    check_eq("A_idx", rd_idx, 8'h01);
    nxt();
    req_i[0].tag_valid = 1; req_i[0].address_tag = 20'h80001; hit_oh = 4'b0001; #1;
    check_eq("B_rv", rv_v, 3'b001);
    check_eq("B_gnt", gnt_v, 3'b000);
    check_eq("B_tag", rd_tag, 20'h80001);
    check_eq("rdata_bcast", req_o[2].data_rdata, 64'hdead_beef_0123_4567);

    // C: ports 0 and 2 with rr=1 -> port2
    nxt();
    req_i[0].data_req = 1; req_i[0].address_index = 12'h050;
    req_i[2].data_req = 1; req_i[2].address_index = 12'h2a0; rd_ack = 1; #1;
    txn("arb ports 0,2 rr=1");
    check_eq("C_gnt", gnt_v, 3'b100);
    check_eq("C_idx", rd_idx, 8'h2a);
    nxt();
    req_i[2].tag_valid = 1; req_i[2].address_tag = 20'h80002; hit_oh = 4'b0100;
    req_i[0].data_req = 1; rd_ack = 1; #1;
    check_eq("D_rv", rv_v, 3'b100);
    check_eq("D_gnt", gnt_v, 3'b001);

    // E: port0 misses (cacheable)
    nxt();
    req_i[0].tag_valid = 1; req_i[0].address_tag = 20'h80003; #1;
    txn("cacheable miss port0");
    check_eq("E_rv", rv_v, 3'b000);
    check_eq("E_tag", rd_tag, 20'h80003);
    nxt(); #1;
    check_eq("F_miss_req", miss_req, 1);
    check_eq("F_rd_req", rd_req, 0);
    check_eq("F_paddr", miss_paddr, 32'h8000_3050);
    check_eq("F_nc", miss_nc, 0);
    check_eq("F_size", miss_size, 3'b111);
    check_eq("F_vld", miss_vld, 4'b1011);
    check_eq("F_dcs", miss_dcs, 4'h5);
    nxt(); miss_ack = 1; #1;
    check_eq("G_miss_req", miss_req, 1);
    nxt(); #1;
    check_eq("H_miss_req", miss_req, 0);
    check_eq("H_rv", rv_v, 3'b000);
    nxt(); rtrn = 1; #1;
    check_eq("I_rv", rv_v, 3'b001);
    nxt(); #1;
    check_eq("J_rd_req", rd_req, 0);

    // Port1 hit, rr=1
    nxt();
    req_i[1].data_req = 1; req_i[1].address_index = 12'h100; rd_ack = 1; #1;
    txn("hit port1");
    check_eq("K_gnt", gnt_v, 3'b010);
    check_eq("K_rv", rv_v, 3'b000);
    nxt();
    req_i[1].tag_valid = 1; req_i[1].address_tag = 20'h80010; hit_oh = 4'b0010; #1;
    check_eq("L_rv", rv_v, 3'b010);
    nxt(); #1;
    check_eq("L1_rv", rv_v, 3'b000);

    // NC miss with cache disabled, rr=2
    nxt();
    cache_en = 0;
    req_i[2].data_req = 1; req_i[2].address_index = 12'h3c8; req_i[2].data_size = 2'd2; rd_ack = 1; #1;
    txn("nc miss port2");
    check_eq("M_gnt", gnt_v, 3'b100);
    nxt();
    req_i[2].tag_valid = 1; req_i[2].address_tag = 20'h80004; hit_oh = 4'b0001; #1;
    check_eq("N_rv", rv_v, 3'b000);
    nxt(); miss_ack = 1; #1;
    check_eq("O_miss_req", miss_req, 1);
    check_eq("O_nc", miss_nc, 1);
    check_eq("O_size", miss_size, 3'b010);
    check_eq("O_paddr", miss_paddr, 32'h8000_43c8);
    for (int w = 0; w < 4; w++) begin
      nxt(); #1;
      check_eq("W_rv", rv_v, 3'b000);
    end
    nxt(); rtrn = 1; #1;
    check_eq("W5_rv", rv_v, 3'b100);
    nxt(); cache_en = 1; #1;
    check_eq("nc_idle_rd_req", rd_req, 0);

    // Kill in MISS_REQ without ack, rr=0
    nxt();
    req_i[0].data_req = 1; req_i[0].address_index = 12'h060; rd_ack = 1; #1;
    txn("kill in miss_req port0");
    check_eq("P_gnt", gnt_v, 3'b001);
    nxt();
    req_i[0].tag_valid = 1; req_i[0].address_tag = 20'h80005; #1;
    nxt(); req_i[0].kill_req = 1; #1;
    check_eq("R_rv", rv_v, 3'b001);
    check_eq("R_miss_req", miss_req, 1);
    nxt(); #1;
    check_eq("S_miss_req", miss_req, 1);
    check_eq("S_rv", rv_v, 3'b000);
    nxt(); miss_ack = 1; #1;
    check_eq("T_miss_req", miss_req, 1);
    nxt(); req_i[1].data_req = 1; rd_ack = 1; #1;
    check_eq("U_miss_req", miss_req, 0);
    check_eq("U_gnt", gnt_v, 3'b000);
    check_eq("U_rd_req", rd_req, 0);
    nxt(); req_i[1].data_req = 1; rd_ack = 1; rtrn = 1; #1;
    check_eq("V_rv", rv_v, 3'b000);
    check_eq("V_gnt", gnt_v, 3'b000);

    // Replay on line-write collision, rr=1
    nxt();
    req_i[1].data_req = 1; req_i[1].address_index = 12'h070; rd_ack = 1; #1;
    txn("replay port1");
    check_eq("W_gnt", gnt_v, 3'b010);
    nxt();
    req_i[1].tag_valid = 1; req_i[1].address_tag = 20'h80006; wr_cl = 1; hit_oh = 4'b0010;
    req_i[0].data_req = 1; req_i[2].data_req = 1; rd_ack = 1; #1;
    check_eq("X_rv", rv_v, 3'b000);
    check_eq("X_gnt", gnt_v, 3'b000);
    nxt(); req_i[0].data_req = 1; req_i[2].data_req = 1; #1;
    check_eq("Y_rd_req", rd_req, 1);
    check_eq("Y_gnt", gnt_v, 3'b000);
    check_eq("Y_idx", rd_idx, 8'h07);
    check_eq("Y_tag", rd_tag, 20'h80006);
    nxt(); req_i[0].data_req = 1; req_i[2].data_req = 1; rd_ack = 1; #1;
    check_eq("Z_gnt", gnt_v, 3'b000);
    nxt();
    req_i[0].data_req = 1; req_i[2].data_req = 1; req_i[2].address_index = 12'h2b0;
    hit_oh = 4'b0010; rd_ack = 1; #1;
    check_eq("AA_rv", rv_v, 3'b010);
    check_eq("AA_gnt", gnt_v, 3'b100);
    nxt();
    req_i[2].tag_valid = 1; req_i[2].address_tag = 20'h80007; hit_oh = 4'b0100;
    req_i[0].data_req = 1; req_i[0].address_index = 12'h080; rd_ack = 1; #1;
    check_eq("BB_rv", rv_v, 3'b100);
    check_eq("BB_gnt", gnt_v, 3'b001);

    // Miss then reset in MISS_WAIT
    nxt(); req_i[0].tag_valid = 1; req_i[0].address_tag = 20'h80008; #1;
    txn("reset in miss_wait");
    check_eq("CC_rv", rv_v, 3'b000);
    nxt(); miss_ack = 1; #1;
    check_eq("DD_miss_req", miss_req, 1);
    nxt(); #1;
`ifdef WT_DCACHE_CTRL_PERF_EN
    check_eq("hit_cnt", hit_cnt, 5);
    check_eq("miss_cnt", miss_cnt, 3);
`endif
    rst_ni = 0; rtrn = 1; rd_ack = 1;
    for (int i = 0; i < 3; i++) req_i[i].data_req = 1;
    #1;
    check_eq("EE_gnt", gnt_v, 3'b000);
    check_eq("EE_rv", rv_v, 3'b000);
    check_eq("EE_miss_req", miss_req, 0);
    check_eq("EE_rd_req", rd_req, 0);
    nxt(); rst_ni = 1; rtrn = 1; #1;
    check_eq("FF_rv", rv_v, 3'b000);
    check_eq("FF_paddr", miss_paddr, 0);
    check_eq("FF_vld", miss_vld, 0);
    check_eq("FF_miss_req", miss_req, 0);
`ifdef WT_DCACHE_CTRL_PERF_EN
    check_eq("FF_hit_cnt", hit_cnt, 0);
    check_eq("FF_miss_cnt", miss_cnt, 0);
`endif
    nxt(); req_i[1].data_req = 1; req_i[2].data_req = 1; rd_ack = 1; #1;
    txn("post-reset arb");
    check_eq("GG_gnt", gnt_v, 3'b010);

    nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
